// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// UartIF: byte stream handshake between the UART receiver and its consumer.
//   valid : byte on data is available (producer -> consumer)
//   data  : received byte, stable while valid is high
//   ready : consumer accepts the byte; transfer when valid && ready
// Modports: master (producer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface UartIF;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver, LSB first.
//   Synchronises the asynchronous rx line, detects the start bit, samples each
//   bit at mid-bit and presents the byte on a valid/ready handshake. Flags
//   framing errors (stop bit low) and overruns (byte completed while the
//   holding register is still full).
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx           in   serial line, idle high, asynchronous to clk
//   out          UartIF.master: valid (o), data[7:0] (o), ready (i)
//   frame_err    out  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun_err  out  one-cycle pulse: new byte dropped, held byte kept
//
// Configuration
//   UART_RX_MAJORITY_EN  defined: every sample is the 2-of-3 majority of rx_s
//                        around the nominal sample point, decided one cycle
//                        later. Undefined: single sample at the nominal point.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  rx,
    UartIF.master out,
    output logic  frame_err,
    output logic  overrun_err
);

    localparam int unsigned BAUD_TICK = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_TICK = BAUD_TICK / 2;
    localparam int unsigned CNT_W     = $clog2(BAUD_TICK);

    // With majority voting the start decision moves one count later; because
    // DATA restarts its counter from that decision, every later decision is
    // also one cycle later while the counter still tops out at BAUD_TICK-1.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_TGT = CNT_W'(HALF_TICK);
`else
    localparam logic [CNT_W-1:0] START_TGT = CNT_W'(HALF_TICK - 1);
`endif
    localparam logic [CNT_W-1:0] BIT_TGT = CNT_W'(BAUD_TICK - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, rx_s_q, rx_prev_q;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             fall;
    logic             sample_bit;

    assign fall = rx_prev_q && !rx_s_q;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) |
                        (hist_q[0] & rx_s_q);
`else
    assign sample_bit = rx_s_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        valid_d     = valid_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (valid_q && out.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                end
            end

            START: begin
                if (baud_cnt_q == START_TGT) begin
                    baud_cnt_d = '0;
                    if (!sample_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (baud_cnt_q == BIT_TGT) begin
                    baud_cnt_d = '0;
                    shift_d    = {sample_bit, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (baud_cnt_q == BIT_TGT) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    if (sample_bit) begin
                        // A transfer this cycle frees the holding register.
                        if (valid_q && !out.ready) begin
                            overrun_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign out.valid   = valid_q;
    assign out.data    = data_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for uart_rx at default parameters (434 clk/bit).
// Inputs change 1 time unit after the rising edge; outputs and the monitor are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CYC   = 434;
    localparam int FRAME_CYC = 10 * BIT_CYC;

    logic clk;
    logic rst_n;
    logic rx;
    logic frame_err;
    logic overrun_err;

    UartIF u_if ();

    uart_rx #(
        .CLK_FREQ (50000000),
        .BAUD_RATE(115200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .out        (u_if),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Monitor counters: cycles with valid high, transfers, pulse cycles.
    int         valid_cyc = 0;
    int         xfer_cnt  = 0;
    int         ferr_cyc  = 0;
    int         ovr_cyc   = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (u_if.valid) valid_cyc++;
        if (u_if.valid && u_if.ready) begin
            xfer_cnt++;
            last_data = u_if.data;
        end
        if (frame_err) ferr_cyc++;
        if (overrun_err) ovr_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; index i counts clock periods from the start bit.
    // glitch_idx forces rx high for that single period; rst_idx pulses reset
    // there, checks the reset outputs and abandons the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int glitch_idx, input int rst_idx);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(posedge clk);
            #1;
            if (i == rst_idx) begin
                rx    = 1'b1;
                rst_n = 1'b0;
                #1;
                check("rst_mid_valid", {31'd0, u_if.valid}, 32'd0);
                check("rst_mid_data", {24'd0, u_if.data}, 32'h00);
                check("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
                check("rst_mid_ovr", {31'd0, overrun_err}, 32'd0);
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            rx = (i == glitch_idx) ? 1'b1 : frame[i / BIT_CYC];
        end
        @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    int v0, x0, f0, o0;

    task automatic snap();
        v0 = valid_cyc;
        x0 = xfer_cnt;
        f0 = ferr_cyc;
        o0 = ovr_cyc;
    endtask

    initial begin
        rx         = 1'b1;
        rst_n      = 1'b0;
        u_if.ready = 1'b0;
        idle(4);
        sample_point();
        check("rst_valid", {31'd0, u_if.valid}, 32'd0);
        check("rst_data", {24'd0, u_if.data}, 32'h00);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun_err}, 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(10);

        // 1: single byte, consumer always ready.
        u_if.ready = 1'b1;
        snap();
        send_frame(8'h55, 1'b1, -1, -1);
        idle(50);
        sample_point();
        check("t1_xfer", xfer_cnt - x0, 1);
        check("t1_data", {24'd0, last_data}, 32'h55);
        check("t1_valid_cyc", valid_cyc - v0, 1);
        check("t1_ferr", ferr_cyc - f0, 0);
        check("t1_ovr", ovr_cyc - o0, 0);

        // 2: consumer stalled across two frames.
        u_if.ready = 1'b0;
        snap();
        send_frame(8'hA3, 1'b1, -1, -1);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(50);
        sample_point();
        check("t2_valid_held", {31'd0, u_if.valid}, 32'd1);
        check("t2_data_held", {24'd0, u_if.data}, 32'hA3);
        check("t2_ovr_once", ovr_cyc - o0, 1);
        check("t2_no_xfer", xfer_cnt - x0, 0);
        idle(1);
        u_if.ready = 1'b1;
        sample_point();
        check("t2_xfer", xfer_cnt - x0, 1);
        check("t2_xfer_data", {24'd0, last_data}, 32'hA3);
        sample_point();
        check("t2_valid_drop", {31'd0, u_if.valid}, 32'd0);

        // 3: stop bit forced low.
        snap();
        send_frame(8'h81, 1'b0, -1, -1);
        idle(50);
        sample_point();
        check("t3_ferr_pulse", ferr_cyc - f0, 1);
        check("t3_no_valid", valid_cyc - v0, 0);
        check("t3_no_xfer", xfer_cnt - x0, 0);

        // 4: short low pulse is rejected at the start sample.
        snap();
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(700);
        sample_point();
        check("t4_no_valid", valid_cyc - v0, 0);
        check("t4_no_ferr", ferr_cyc - f0, 0);
        check("t4_no_ovr", ovr_cyc - o0, 0);
        snap();
        send_frame(8'h00, 1'b1, -1, -1);
        idle(50);
        sample_point();
        check("t4_xfer", xfer_cnt - x0, 1);
        check("t4_data", {24'd0, last_data}, 32'h00);

        // 5: reset in the middle of data bit 4 while a byte is held.
        u_if.ready = 1'b0;
        send_frame(8'hC7, 1'b1, -1, -1);
        idle(20);
        sample_point();
        check("t5_held_data", {24'd0, u_if.data}, 32'hC7);
        send_frame(8'h5A, 1'b1, -1, 5 * BIT_CYC + BIT_CYC / 2);
        idle(600);
        sample_point();
        check("t5_post_rst_valid", {31'd0, u_if.valid}, 32'd0);
        u_if.ready = 1'b1;
        snap();
        send_frame(8'hF0, 1'b1, -1, -1);
        idle(50);
        sample_point();
        check("t5_xfer", xfer_cnt - x0, 1);
        check("t5_data", {24'd0, last_data}, 32'hF0);

        // 6: one-period high glitch exactly at the bit-0 sample point.
        snap();
        send_frame(8'h00, 1'b1, BIT_CYC + BIT_CYC / 2, -1);
        idle(50);
        sample_point();
        check("t6_xfer", xfer_cnt - x0, 1);
`ifdef UART_RX_MAJORITY_EN
        check("t6_data", {24'd0, last_data}, 32'h00);
`else
        check("t6_data", {24'd0, last_data}, 32'h01);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
